// File: rtl/slave_sink.sv
// Receiving end of a valid/ready word stream: small FIFO toward a downstream port, LFSR-driven
// backpressure, transfer count/XOR checksum and a sticky flag for senders that break hold-while-stalled.
//
// state | meaning
// IDLE  | no stalled word outstanding
// HOLD  | a word was offered while stalled; it must be re-offered unchanged until taken
// ERR   | upstream dropped or changed a stalled word; sticky until reset
module slave_sink #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          STALL_EN  = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_rx_count,
  output logic [DATA_W-1:0] o_rx_xor,
  output logic              o_proto_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam logic [OW-1:0] L_FULL = OW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_occ;
  logic [15:0]       r_lfsr;
  logic              r_run;
  logic [31:0]       r_rx_count;
  logic [DATA_W-1:0] r_rx_xor;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_held;

  logic w_push;
  logic w_pop;
  logic w_lfsr_fb;

  // r_run keeps ready low until the first edge after reset release
  assign o_ready     = r_run && (r_occ != L_FULL) && !(STALL_EN && r_lfsr[0]);
  assign o_out_valid = (r_occ != '0);
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_rx_count  = r_rx_count;
  assign o_rx_xor    = r_rx_xor;
  assign o_proto_err = (r_state == S_ERR);

  assign w_push    = i_valid && o_ready;
  assign w_pop     = o_out_valid && i_out_ready;
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_lfsr     <= LFSR_SEED;
      r_run      <= 1'b0;
      r_rx_count <= '0;
      r_rx_xor   <= '0;
    end else begin
      r_run  <= 1'b1;
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_rx_count <= r_rx_count + 32'd1;
        r_rx_xor   <= r_rx_xor ^ i_data;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_valid && !o_ready) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!i_valid || (i_data != r_held)) w_state_nxt = S_ERR;
        else if (o_ready)                   w_state_nxt = S_IDLE;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && i_valid && !o_ready) begin
        r_held <= i_data;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      $display("Recv Data: 0x%h", i_data);
    end
  end
`endif

endmodule

// File: tb/tb_slave_sink.sv
// Bench for slave_sink: one instance without stalls (d0) and one LFSR-stalled (d1), both compared
// every cycle against a queue-based reference model of the accept/pop/protocol rules.
module tb_slave_sink;

  logic        clk;
  logic        rst_n;
  logic [1:0]  valid;
  logic [1:0]  ordy;
  logic [31:0] data [2];

  logic        rdy0, ov0, err0, rdy1, ov1, err1;
  logic [31:0] od0, cnt0, xr0, od1, cnt1, xr1;

  int checks = 0;
  int errors = 0;

  bit [15:0]   m_lfsr [2];
  bit          m_run  [2];
  bit          m_err  [2];
  bit          m_pend [2];
  logic [31:0] m_held [2];
  logic [31:0] m_cnt  [2];
  logic [31:0] m_xor  [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  slave_sink #(.DATA_W(32), .DEPTH(4), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]), .o_ready(rdy0),
    .o_out_data(od0), .o_out_valid(ov0), .i_out_ready(ordy[0]), .o_rx_count(cnt0),
    .o_rx_xor(xr0), .o_proto_err(err0));

  slave_sink #(.DATA_W(32), .DEPTH(4), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]), .o_ready(rdy1),
    .o_out_data(od1), .o_out_valid(ov1), .i_out_ready(ordy[1]), .o_rx_count(cnt1),
    .o_rx_xor(xr1), .o_proto_err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^16+x^14+x^13+x^11+1, tap t read from bit 16-t, shifted in at the top
  function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
    int taps [4] = '{16, 14, 13, 11};
    bit fb = 1'b0;
    for (int k = 0; k < 4; k++) fb ^= s[16 - taps[k]];
    return {fb, s[15:1]};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit mready(input int i);
    return m_run[i] && (qsize(i) != 4) && !((i == 1) && m_lfsr[i][0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1;
      m_run[i]  = 1'b0;
      m_err[i]  = 1'b0;
      m_pend[i] = 1'b0;
      m_held[i] = '0;
      m_cnt[i]  = '0;
      m_xor[i]  = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(input int i);
    bit          rdy, acc, pop, v;
    logic [31:0] d;
    v   = valid[i];
    d   = data[i];
    rdy = mready(i);
    acc = v && rdy;
    pop = (qsize(i) != 0) && ordy[i];
    if (!m_err[i]) begin
      if (m_pend[i]) begin
        if (!v || (d !== m_held[i])) m_err[i] = 1'b1;
        else if (rdy)                m_pend[i] = 1'b0;
      end else if (v && !rdy) begin
        m_pend[i] = 1'b1;
        m_held[i] = d;
      end
    end
    if (pop) begin
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    if (acc) begin
      if (i == 0) q0.push_back(d);
      else        q1.push_back(d);
      m_cnt[i] = m_cnt[i] + 32'd1;
      m_xor[i] = m_xor[i] ^ d;
    end
    m_lfsr[i] = lfsr_adv(m_lfsr[i]);
    m_run[i]  = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_out(input int i, output logic r, output logic ov, output logic [31:0] od,
                         output logic [31:0] cnt, output logic [31:0] xr, output logic e);
    if (i == 0) begin r = rdy0; ov = ov0; od = od0; cnt = cnt0; xr = xr0; e = err0; end
    else        begin r = rdy1; ov = ov1; od = od1; cnt = cnt1; xr = xr1; e = err1; end
  endtask

  task automatic check_all(input int i);
    logic r, ov, e;
    logic [31:0] od, cnt, xr;
    get_out(i, r, ov, od, cnt, xr, e);
    chk($sformatf("d%0d_ready", i), r, mready(i));
    chk($sformatf("d%0d_out_valid", i), ov, qsize(i) != 0);
    if (qsize(i) != 0) chk($sformatf("d%0d_out_data", i), od, qhead(i));
    chk($sformatf("d%0d_rx_count", i), cnt, m_cnt[i]);
    chk($sformatf("d%0d_rx_xor", i), xr, m_xor[i]);
    chk($sformatf("d%0d_proto_err", i), e, m_err[i]);
  endtask

  task automatic check_zero(input int i);
    logic r, ov, e;
    logic [31:0] od, cnt, xr;
    get_out(i, r, ov, od, cnt, xr, e);
    chk($sformatf("d%0d_rst_ready", i), r, 0);
    chk($sformatf("d%0d_rst_out_valid", i), ov, 0);
    chk($sformatf("d%0d_rst_rx_count", i), cnt, 0);
    chk($sformatf("d%0d_rst_rx_xor", i), xr, 0);
    chk($sformatf("d%0d_rst_proto_err", i), e, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  // Asserted off-edge so the asynchronous clear is observed without any clock
  task automatic do_reset();
    rst_n = 1'b0;
    valid = 2'b00;
    #1;
    check_zero(0);
    check_zero(1);
    @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    bit r0, r1;
    int n;
    rst_n   = 1'b1;
    valid   = 2'b00;
    ordy    = 2'b00;
    data[0] = '0;
    data[1] = '0;
    #3;
    do_reset();

    // back-to-back 1,2,3 through the non-stalling sink
    ordy = 2'b11;
    step();
    valid[0] = 1'b1;
    data[0]  = 32'h1; step();
    data[0]  = 32'h2; step();
    data[0]  = 32'h3; step();
    valid[0] = 1'b0;
    step();
    step();
    chk("t1_count", cnt0, 32'd3);
    chk("t1_xor", xr0, 32'h0);

    // fill to DEPTH, hold the fifth word while full, then drain
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid[0] = 1'b1;
      data[0]  = 32'(32'hA0 + k);
      step();
    end
    data[0] = 32'hA4;
    step();
    chk("t2_full_ready", rdy0, 1'b0);
    step();
    ordy[0] = 1'b1;
    step();
    step();
    valid[0] = 1'b0;
    repeat (6) step();
    chk("t2_count", cnt0, 32'd8);

    // random traffic; stalled words are always re-offered unchanged
    valid[1] = 1'b1;
    data[1]  = $urandom;
    ordy[1]  = 1'b1;
    for (int c = 0; c < 64; c++) begin
      r0 = mready(0);
      r1 = mready(1);
      step();
      if (r1) data[1] = $urandom;
      if (!(valid[0] && !r0)) begin
        valid[0] = 1'($urandom_range(0, 1));
        data[0]  = $urandom;
      end
      ordy[0] = 1'($urandom_range(0, 1));
    end
    ordy[0] = 1'b1;
    n = 0;
    while ((valid != 2'b00) && (n < 60)) begin
      r0 = mready(0);
      r1 = mready(1);
      step();
      if (!(valid[0] && !r0)) valid[0] = 1'b0;
      if (!(valid[1] && !r1)) valid[1] = 1'b0;
      n++;
    end
    chk("t3_drained", {30'd0, valid}, 32'd0);
    chk("t3_err0", err0, 1'b0);
    chk("t3_err1", err1, 1'b0);

    // change a stalled word on the stalling sink
    for (n = 0; (n < 50) && mready(1); n++) step();
    chk("t4_stall", rdy1, 1'b0);
    valid[1] = 1'b1;
    data[1]  = 32'hDEADBEEF;
    step();
    data[1] = 32'hDEADBEF0;
    step();
    chk("t4_err", err1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      r1 = mready(1);
      step();
      if (r1) data[1] = $urandom;
    end
    valid[1] = 1'b0;
    step();
    chk("t4_sticky", err1, 1'b1);

    // drop a stalled word on the non-stalling sink (stall by filling the FIFO)
    chk("t5_pre", err0, 1'b0);
    ordy[0]  = 1'b0;
    valid[0] = 1'b1;
    data[0]  = $urandom;
    for (n = 0; (n < 10) && mready(0); n++) begin
      step();
      data[0] = $urandom;
    end
    chk("t5_full", rdy0, 1'b0);
    step();
    valid[0] = 1'b0;
    step();
    chk("t5_err", err0, 1'b1);

    // asynchronous reset with words in flight
    #2;
    do_reset();
    ordy[0] = 1'b0;
    step();
    valid[0] = 1'b1;
    data[0]  = 32'h11; step();
    data[0]  = 32'h22; step();
    valid[0] = 1'b0;
    step();
    chk("t6_two_valid", ov0, 1'b1);
    chk("t6_two_count", cnt0, 32'd2);
    #2;
    do_reset();
    ordy[0] = 1'b1;
    step();
    valid[0] = 1'b1;
    data[0]  = 32'h55;
    step();
    chk("t6_first_out", od0, 32'h55);
    valid[0] = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
